// File: rtl/mc_pkg.sv
// mc_pkg: shared op/state enums and 2R cell encoding {m1,m0} for the memristor array controller
package mc_pkg;
  typedef enum logic {MC_READ = 1'b0, MC_WRITE = 1'b1} mc_op_e;
  typedef enum logic [2:0] {IDLE, WR_RST, WR_SET, RD_PRE, RD_EVAL, RESP} mc_state_e;
  typedef logic [1:0] cell_t;
  localparam cell_t CELL_ONE      = 2'b01;
  localparam cell_t CELL_ZERO     = 2'b10;
  localparam cell_t CELL_UNFORMED = 2'b00;
endpackage

// File: rtl/mc_array_ctrl_if.sv
// mc_array_ctrl_if: request (valid/ready, op/row/wdata/din/dinb) and response (valid/ready, data/mask/err) channels; master = datapath, slave = controller
interface mc_array_ctrl_if import mc_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) ();
  localparam int RW = $clog2(ROWS);
  logic            req_valid_i;
  logic            req_ready_o;
  mc_op_e          req_op_i;
  logic [RW-1:0]   req_row_i;
  logic [COLS-1:0] req_wdata_i;
  logic [COLS-1:0] req_din_i;
  logic [COLS-1:0] req_dinb_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [COLS-1:0] rsp_data_o;
  logic [COLS-1:0] rsp_mask_o;
  logic            rsp_err_o;
  modport master (
    output req_valid_i, req_op_i, req_row_i, req_wdata_i, req_din_i, req_dinb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_mask_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_op_i, req_row_i, req_wdata_i, req_din_i, req_dinb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_mask_o, rsp_err_o
  );
endinterface

// File: rtl/mc_cell_sync.sv
// mc_cell_sync: one non-volatile 2R cell (clk_i; clr/set/wbit program it, din/dinb select likelihood -> dout, decided = m0!=m1)
module mc_cell_sync import mc_pkg::*; (
  input  logic clk_i,
  input  logic clr,
  input  logic set,
  input  logic wbit,
  input  logic din,
  input  logic dinb,
  output logic dout,
  output logic decided
);
  cell_t c = CELL_UNFORMED;
  always_ff @(posedge clk_i)
    if (clr) c <= CELL_UNFORMED;
    else if (set) c <= wbit ? CELL_ONE : CELL_ZERO;
  assign dout    = ~((c[0] & din) | (c[1] & dinb));
  assign decided = c[0] ^ c[1];
endmodule

// File: rtl/mc_array_ctrl.sv
// mc_array_ctrl: ROWSxCOLS 2R array sequencer (clk_i, sync rst_i, bus = slave request/response channels, busy_o = FSM not idle)
module mc_array_ctrl import mc_pkg::*; #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int PULSE_CYC = 2,
  parameter int READ_CYC  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mc_array_ctrl_if.slave       bus,
  output logic                 busy_o
);
  localparam int RW = $clog2(ROWS);
  localparam int MX = PULSE_CYC > READ_CYC ? PULSE_CYC : READ_CYC;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  mc_state_e                  state;
  logic [CW-1:0]              cnt;
  logic [RW-1:0]              row_q;
  logic [COLS-1:0]            wdata_q, din_q, dinb_q;
  logic                       p_last, r_last, clr_en, set_en;
  logic [ROWS-1:0][COLS-1:0]  dout_a, dec_a;
  logic [COLS-1:0]            rd_dout, rd_dec;
  assign p_last = cnt == CW'(PULSE_CYC - 1);
  assign r_last = cnt == CW'(READ_CYC - 1);
  assign clr_en = state == WR_RST && p_last && !rst_i;
  assign set_en = state == WR_SET && p_last && !rst_i;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mc_cell_sync u_cell (
        .clk_i   (clk_i),
        .clr     (clr_en && row_q == RW'(r)),
        .set     (set_en && row_q == RW'(r)),
        .wbit    (wdata_q[c]),
        .din     (din_q[c]),
        .dinb    (dinb_q[c]),
        .dout    (dout_a[r][c]),
        .decided (dec_a[r][c])
      );
    end
  end
  always_comb begin
    rd_dout = '0;
    rd_dec  = '0;
    for (int r = 0; r < ROWS; r++) begin
      rd_dout = row_q == RW'(r) ? dout_a[r] : rd_dout;
      rd_dec  = row_q == RW'(r) ? dec_a[r]  : rd_dec;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.req_ready_o <= 1'b1;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_data_o  <= '0;
      bus.rsp_mask_o  <= '0;
      bus.rsp_err_o   <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid_i) begin
          row_q           <= bus.req_row_i;
          wdata_q         <= bus.req_wdata_i;
          din_q           <= bus.req_din_i;
          dinb_q          <= bus.req_dinb_i;
          cnt             <= '0;
          bus.req_ready_o <= 1'b0;
          busy_o          <= 1'b1;
          if (32'(bus.req_row_i) >= ROWS) begin
            state           <= RESP;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_data_o  <= '0;
            bus.rsp_mask_o  <= '0;
          end else begin
            state <= bus.req_op_i == MC_WRITE ? WR_RST : RD_PRE;
          end
        end
        WR_RST: begin
          cnt   <= p_last ? '0 : cnt + 1'b1;
          state <= p_last ? WR_SET : WR_RST;
        end
        WR_SET: begin
          cnt <= p_last ? '0 : cnt + 1'b1;
          if (p_last) begin
            state           <= RESP;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_data_o  <= wdata_q;
            bus.rsp_mask_o  <= '1;
          end
        end
        RD_PRE: begin
          cnt   <= r_last ? '0 : cnt + 1'b1;
          state <= r_last ? RD_EVAL : RD_PRE;
        end
        RD_EVAL: begin
          state           <= RESP;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_err_o   <= 1'b0;
          bus.rsp_data_o  <= rd_dout & rd_dec;
          bus.rsp_mask_o  <= rd_dec;
        end
        RESP: if (bus.rsp_ready_i) begin
          state           <= IDLE;
          bus.rsp_valid_o <= 1'b0;
          bus.req_ready_o <= 1'b1;
          busy_o          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_array_ctrl.sv
// tb_mc_array_ctrl: table-driven and sequence checks of mc_array_ctrl at ROWS=8 and ROWS=6
module tb_mc_array_ctrl;
  import mc_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, rsp_ready = 0, sel = 0;
  mc_op_e op = MC_READ;
  logic [2:0] row = '0;
  logic [7:0] wdata = '0, din = '0, dinb = '0;
  logic busy8, busy6;
  int n_chk = 0, n_fail = 0;
  mc_array_ctrl_if #(.ROWS(8), .COLS(8)) b8 ();
  mc_array_ctrl_if #(.ROWS(6), .COLS(8)) b6 ();
  mc_array_ctrl #(.ROWS(8), .COLS(8), .PULSE_CYC(2), .READ_CYC(1)) u8 (
    .clk_i(clk), .rst_i(rst), .bus(b8.slave), .busy_o(busy8));
  mc_array_ctrl #(.ROWS(6), .COLS(8), .PULSE_CYC(2), .READ_CYC(1)) u6 (
    .clk_i(clk), .rst_i(rst), .bus(b6.slave), .busy_o(busy6));
  assign b8.req_valid_i = req_valid & ~sel;
  assign b6.req_valid_i = req_valid & sel;
  assign b8.rsp_ready_i = rsp_ready & ~sel;
  assign b6.rsp_ready_i = rsp_ready & sel;
  assign b8.req_op_i = op;
  assign b6.req_op_i = op;
  assign b8.req_row_i = row;
  assign b6.req_row_i = row;
  assign b8.req_wdata_i = wdata;
  assign b6.req_wdata_i = wdata;
  assign b8.req_din_i = din;
  assign b6.req_din_i = din;
  assign b8.req_dinb_i = dinb;
  assign b6.req_dinb_i = dinb;
  logic o_ready, o_valid, o_err, o_busy;
  logic [7:0] o_data, o_mask;
  assign o_ready = sel ? b6.req_ready_o : b8.req_ready_o;
  assign o_valid = sel ? b6.rsp_valid_o : b8.rsp_valid_o;
  assign o_err   = sel ? b6.rsp_err_o   : b8.rsp_err_o;
  assign o_data  = sel ? b6.rsp_data_o  : b8.rsp_data_o;
  assign o_mask  = sel ? b6.rsp_mask_o  : b8.rsp_mask_o;
  assign o_busy  = sel ? busy6 : busy8;
  typedef struct {
    mc_op_e     op;
    logic       sel;
    logic [2:0] row;
    logic [7:0] wdata, din, dinb;
    int         lat;
    logic [7:0] data, mask;
    logic       err;
  } vec_t;
  vec_t tv[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic present(input vec_t v);
    int n = 0;
    sel = v.sel; op = v.op; row = v.row; wdata = v.wdata; din = v.din; dinb = v.dinb;
    req_valid = 1;
    while (!o_ready && n < 50) begin cyc(); n++; end
    chk("accept_ready", 32'(o_ready), 1);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!o_valid && lat < 50) begin cyc(); lat++; end
    chk("rsp_timeout", 32'(o_valid), 1);
  endtask
  task automatic handshake();
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    present(v);
    cyc();
    req_valid = 0;
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_data"}, 32'(o_data), 32'(v.data));
    chk({tag, "_mask"}, 32'(o_mask), 32'(v.mask));
    chk({tag, "_err"}, 32'(o_err), 32'(v.err));
    handshake();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    int lat;
    logic seen;
    tv[0]  = '{MC_READ,  1'b0, 3'd3, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'h00, 1'b0};
    tv[1]  = '{MC_WRITE, 1'b0, 3'd5, 8'hA5, 8'h00, 8'h00, 5, 8'hA5, 8'hFF, 1'b0};
    tv[2]  = '{MC_READ,  1'b0, 3'd5, 8'h00, 8'hFF, 8'h00, 3, 8'h5A, 8'hFF, 1'b0};
    tv[3]  = '{MC_READ,  1'b0, 3'd5, 8'h00, 8'h00, 8'hFF, 3, 8'hA5, 8'hFF, 1'b0};
    tv[4]  = '{MC_WRITE, 1'b0, 3'd0, 8'h3C, 8'h00, 8'h00, 5, 8'h3C, 8'hFF, 1'b0};
    tv[5]  = '{MC_WRITE, 1'b0, 3'd0, 8'hC3, 8'h00, 8'h00, 5, 8'hC3, 8'hFF, 1'b0};
    tv[6]  = '{MC_READ,  1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 3, 8'h3C, 8'hFF, 1'b0};
    tv[7]  = '{MC_WRITE, 1'b1, 3'd1, 8'h0F, 8'h00, 8'h00, 5, 8'h0F, 8'hFF, 1'b0};
    tv[8]  = '{MC_WRITE, 1'b1, 3'd7, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1'b1};
    tv[9]  = '{MC_READ,  1'b1, 3'd1, 8'h00, 8'hFF, 8'h00, 3, 8'hF0, 8'hFF, 1'b0};
    tv[10] = '{MC_READ,  1'b1, 3'd4, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'h00, 1'b0};
    tv[11] = '{MC_WRITE, 1'b1, 3'd6, 8'hAA, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1'b1};
    tv[12] = '{MC_READ,  1'b1, 3'd0, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'h00, 1'b0};
    tv[13] = '{MC_READ,  1'b1, 3'd5, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'h00, 1'b0};
    repeat (3) cyc();
    rst = 0;
    cyc();
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_mask", 32'(o_mask), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_busy", 32'(o_busy), 0);
    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tv[i]);
    v = '{MC_READ, 1'b0, 3'd5, 8'h00, 8'hFF, 8'h00, 3, 8'h5A, 8'hFF, 1'b0};
    present(v);
    cyc();
    row = 3'd0;
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 3);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", 32'(o_valid), 1);
      chk("bp_data", 32'(o_data), 32'h5A);
      chk("bp_mask", 32'(o_mask), 32'hFF);
      chk("bp_ready", 32'(o_ready), 0);
      chk("bp_busy", 32'(o_busy), 1);
    end
    handshake();
    chk("bp_valid_drop", 32'(o_valid), 0);
    chk("bp_bubble_idle", 32'(o_busy), 0);
    chk("bp_bubble_ready", 32'(o_ready), 1);
    cyc();
    req_valid = 0;
    chk("bp_second_busy", 32'(o_busy), 1);
    chk("bp_second_ready", 32'(o_ready), 0);
    wait_rsp(lat);
    chk("bp_second_lat", 32'(lat), 3);
    chk("bp_second_data", 32'(o_data), 32'h3C);
    handshake();
    v = '{MC_WRITE, 1'b0, 3'd2, 8'hFF, 8'h00, 8'h00, 5, 8'hFF, 8'hFF, 1'b0};
    present(v);
    cyc();
    req_valid = 0;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen |= o_valid;
      cyc();
    end
    chk("rst_mid_no_rsp", 32'(seen), 0);
    chk("rst_mid_ready", 32'(o_ready), 1);
    chk("rst_mid_busy", 32'(o_busy), 0);
    run_vec("rst_row2", '{MC_READ, 1'b0, 3'd2, 8'h00, 8'hFF, 8'h00, 3, 8'h00, 8'h00, 1'b0});
    run_vec("rst_row5", '{MC_READ, 1'b0, 3'd5, 8'h00, 8'hFF, 8'h00, 3, 8'h5A, 8'hFF, 1'b0});
    run_vec("rst_u6_row1", '{MC_READ, 1'b1, 3'd1, 8'h00, 8'hFF, 8'h00, 3, 8'hF0, 8'hFF, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
